alu_arbiter: RTL and testbench

Sequencing controller and round-robin arbiter that shares the single 64-bit ALU between two requesters (req0 = execute stage, req1 = address/auxiliary unit). It latches one operation at a time, holds the operands steady on the ALU inputs for the required number of cycles, and samples `result`/`zero`. It returns the sampled values to the requester that issued the operation. It also intercepts divide-by-zero so the ALU never sees it.

---
 rtl/alu_arbiter_if.sv | 51 +++++
 rtl/alu_arbiter.sv | 107 ++++++++++
 tb/tb_alu_arbiter.sv | 260 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/alu_arbiter_if.sv
// Requester, response and ALU-side signals of the shared-ALU arbiter.
// The slave side is the arbiter; the master side is the requesters plus the ALU.
interface alu_arbiter_if #(
  parameter int WIDTH = 64
);
  logic             req0_valid;
  logic             req0_ready;
  logic [2:0]       req0_op;
  logic [WIDTH-1:0] req0_a;
  logic [WIDTH-1:0] req0_b;
  logic             req1_valid;
  logic             req1_ready;
  logic [2:0]       req1_op;
  logic [WIDTH-1:0] req1_a;
  logic [WIDTH-1:0] req1_b;

  logic             rsp0_valid;
  logic [WIDTH-1:0] rsp0_result;
  logic             rsp0_zero;
  logic             rsp0_err;
  logic             rsp1_valid;
  logic [WIDTH-1:0] rsp1_result;
  logic             rsp1_zero;
  logic             rsp1_err;

  logic [2:0]       alu_operation;
  logic [WIDTH-1:0] alu_a;
  logic [WIDTH-1:0] alu_b;
  logic [WIDTH-1:0] alu_result;
  logic             alu_zero;

  modport slave (
    input  req0_valid, req0_op, req0_a, req0_b,
    input  req1_valid, req1_op, req1_a, req1_b,
    input  alu_result, alu_zero,
    output req0_ready, req1_ready,
    output rsp0_valid, rsp0_result, rsp0_zero, rsp0_err,
    output rsp1_valid, rsp1_result, rsp1_zero, rsp1_err,
    output alu_operation, alu_a, alu_b
  );

  modport master (
    output req0_valid, req0_op, req0_a, req0_b,
    output req1_valid, req1_op, req1_a, req1_b,
    output alu_result, alu_zero,
    input  req0_ready, req1_ready,
    input  rsp0_valid, rsp0_result, rsp0_zero, rsp0_err,
    input  rsp1_valid, rsp1_result, rsp1_zero, rsp1_err,
    input  alu_operation, alu_a, alu_b
  );
endinterface

// File: rtl/alu_arbiter.sv
// Round-robin sequencer sharing one ALU between two requesters; response 2 cycles after accept
// (LONG_LAT+1 for mul/div). Ready only in IDLE; responses are single-cycle pulses with no backpressure.
module alu_arbiter #(
  parameter int WIDTH    = 64,
  parameter int LONG_LAT = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  alu_arbiter_if.slave  bus
);
  localparam logic [2:0] OP_NOP = 3'b000;
  localparam logic [2:0] OP_DIV = 3'b011;
  localparam logic [2:0] OP_MUL = 3'b100;

  typedef enum logic {IDLE, BUSY} state_t;

  state_t           state;
  logic             last;
  logic             owner;
  logic             div_zero;
  logic [3:0]       cnt;

  logic             gnt0;
  logic             gnt1;
  logic             idle;
  logic [2:0]       sel_op;
  logic [WIDTH-1:0] sel_a;
  logic [WIDTH-1:0] sel_b;
  logic             sel_dz;
  logic             sel_long;

  // last==1 means req1 was served most recently, so req0 wins the next tie.
  always_comb begin
    gnt0     = bus.req0_valid && (!bus.req1_valid || last);
    gnt1     = bus.req1_valid && (!bus.req0_valid || !last);
    idle     = (state == IDLE) && rst_n;
    sel_op   = gnt1 ? bus.req1_op : bus.req0_op;
    sel_a    = gnt1 ? bus.req1_a  : bus.req0_a;
    sel_b    = gnt1 ? bus.req1_b  : bus.req0_b;
    sel_dz   = (sel_op == OP_DIV) && (sel_b == '0);
    sel_long = ((sel_op == OP_MUL) || (sel_op == OP_DIV)) && !sel_dz;
  end

  assign bus.req0_ready = idle && gnt0;
  assign bus.req1_ready = idle && gnt1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state             <= IDLE;
      last              <= 1'b1;
      owner             <= 1'b0;
      div_zero          <= 1'b0;
      cnt               <= '0;
      bus.alu_operation <= OP_NOP;
      bus.alu_a         <= '0;
      bus.alu_b         <= '0;
      bus.rsp0_valid    <= 1'b0;
      bus.rsp0_result   <= '0;
      bus.rsp0_zero     <= 1'b0;
      bus.rsp0_err      <= 1'b0;
      bus.rsp1_valid    <= 1'b0;
      bus.rsp1_result   <= '0;
      bus.rsp1_zero     <= 1'b0;
      bus.rsp1_err      <= 1'b0;
    end else begin
      bus.rsp0_valid <= 1'b0;
      bus.rsp1_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (gnt0 || gnt1) begin
            state             <= BUSY;
            owner             <= gnt1;
            last              <= gnt1;
            div_zero          <= sel_dz;
            cnt               <= sel_long ? 4'(LONG_LAT - 1) : 4'd0;
            // A zero divisor never reaches the ALU; it sees a no-op instead.
            bus.alu_operation <= sel_dz ? OP_NOP : sel_op;
            bus.alu_a         <= sel_a;
            bus.alu_b         <= sel_b;
          end
        end
        BUSY: begin
          if (cnt == 4'd0) begin
            state             <= IDLE;
            bus.alu_operation <= OP_NOP;
            bus.alu_a         <= '0;
            bus.alu_b         <= '0;
            if (owner) begin
              bus.rsp1_valid  <= 1'b1;
              bus.rsp1_result <= div_zero ? '0 : bus.alu_result;
              bus.rsp1_zero   <= div_zero ? 1'b1 : bus.alu_zero;
              bus.rsp1_err    <= div_zero;
            end else begin
              bus.rsp0_valid  <= 1'b1;
              bus.rsp0_result <= div_zero ? '0 : bus.alu_result;
              bus.rsp0_zero   <= div_zero ? 1'b1 : bus.alu_zero;
              bus.rsp0_err    <= div_zero;
            end
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter with a behavioural 64-bit ALU attached.
module tb_alu_arbiter;
  localparam int W  = 64;
  localparam int LL = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  alu_arbiter_if #(.WIDTH(W)) bus();

  alu_arbiter #(.WIDTH(W), .LONG_LAT(LL)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // Reference ALU: 001 sub, 010 add, 011 div, 100 mul, anything else returns 0.
  always_comb begin
    case (bus.alu_operation)
      3'b001:  bus.alu_result = bus.alu_a - bus.alu_b;
      3'b010:  bus.alu_result = bus.alu_a + bus.alu_b;
      3'b011:  bus.alu_result = (bus.alu_b != '0) ? bus.alu_a / bus.alu_b : '0;
      3'b100:  bus.alu_result = bus.alu_a * bus.alu_b;
      default: bus.alu_result = '0;
    endcase
    bus.alu_zero = (bus.alu_result == '0);
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_cmp  = 0;
  int n_fail = 0;

  typedef struct {
    int          port;
    logic [2:0]  op;
    logic [63:0] a;
    logic [63:0] b;
    logic [2:0]  aop;
    logic [63:0] res;
    logic        z;
    logic        e;
    int          lat;
  } vec_t;

  vec_t vecs[7];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic rdy(input int p);
    return (p == 1) ? bus.req1_ready : bus.req0_ready;
  endfunction
  function automatic logic rvld(input int p);
    return (p == 1) ? bus.rsp1_valid : bus.rsp0_valid;
  endfunction
  function automatic logic [63:0] rres(input int p);
    return (p == 1) ? bus.rsp1_result : bus.rsp0_result;
  endfunction
  function automatic logic rzero(input int p);
    return (p == 1) ? bus.rsp1_zero : bus.rsp0_zero;
  endfunction
  function automatic logic rerr(input int p);
    return (p == 1) ? bus.rsp1_err : bus.rsp0_err;
  endfunction

  task automatic drive(input int p, input logic v, input logic [2:0] op,
                       input logic [63:0] a, input logic [63:0] b);
    if (p == 1) begin
      bus.req1_valid = v; bus.req1_op = op; bus.req1_a = a; bus.req1_b = b;
    end else begin
      bus.req0_valid = v; bus.req0_op = op; bus.req0_a = a; bus.req0_b = b;
    end
  endtask

  // Issue one op from a lone requester, then check accept, hold stability, latency and response.
  task automatic run_op(input int idx, input vec_t v);
    int  t;
    int  lat_seen;
    bit  got;
    bit  stable;
    bit  other;
    t = 0; lat_seen = -1; got = 0; stable = 1; other = 0;
    drive(v.port, 1'b1, v.op, v.a, v.b);
    #1;
    for (int k = 0; k < 20 && !got; k++) begin
      if (rdy(v.port)) begin
        got = 1;
        t = cyc;
      end else begin
        @(negedge clk); #1;
      end
    end
    chk($sformatf("v%0d_accept", idx), 64'(got), 64'd1);
    @(posedge clk); #1;
    drive(v.port, 1'b0, 3'b000, 64'd0, 64'd0);
    for (int k = 0; k < 20 && lat_seen < 0; k++) begin
      @(negedge clk); #1;
      if (rvld(1 - v.port)) other = 1;
      if (rvld(v.port)) begin
        lat_seen = cyc - t;
        chk($sformatf("v%0d_idle_alu_op", idx), 64'(bus.alu_operation), 64'd0);
      end else if (bus.alu_operation !== v.aop || bus.alu_a !== v.a || bus.alu_b !== v.b) begin
        stable = 0;
      end
    end
    chk($sformatf("v%0d_latency", idx), 64'(lat_seen), 64'(v.lat));
    chk($sformatf("v%0d_alu_hold", idx), 64'(stable), 64'd1);
    chk($sformatf("v%0d_other_rsp", idx), 64'(other), 64'd0);
    chk($sformatf("v%0d_result", idx), rres(v.port), v.res);
    chk($sformatf("v%0d_zero", idx), 64'(rzero(v.port)), 64'(v.z));
    chk($sformatf("v%0d_err", idx), 64'(rerr(v.port)), 64'(v.e));
  endtask

  initial begin
    int g[$];
    int acc[2];
    int pend[2];
    bit dropped;
    bit ok;
    int t;

    vecs[0] = '{0, 3'b010, 64'd5,   64'd7, 3'b010, 64'd12, 1'b0, 1'b0, 2};
    vecs[1] = '{1, 3'b001, 64'd9,   64'd9, 3'b001, 64'd0,  1'b1, 1'b0, 2};
    vecs[2] = '{1, 3'b011, 64'd100, 64'd0, 3'b000, 64'd0,  1'b1, 1'b1, 2};
    vecs[3] = '{1, 3'b011, 64'd100, 64'd7, 3'b011, 64'd14, 1'b0, 1'b0, LL + 1};
    vecs[4] = '{0, 3'b100, 64'd6,   64'd7, 3'b100, 64'd42, 1'b0, 1'b0, LL + 1};
    vecs[5] = '{0, 3'b110, 64'd3,   64'd4, 3'b110, 64'd0,  1'b1, 1'b0, 2};
    vecs[6] = '{1, 3'b010, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 3'b010, 64'd0, 1'b1, 1'b0, 2};

    drive(0, 1'b1, 3'b010, 64'd1, 64'd1);
    drive(1, 1'b0, 3'b000, 64'd0, 64'd0);

    // Reset state, with a requester already valid.
    @(negedge clk); @(negedge clk); #1;
    chk("rst_ready0", 64'(bus.req0_ready), 64'd0);
    chk("rst_rsp0_valid", 64'(bus.rsp0_valid), 64'd0);
    chk("rst_rsp1_result", bus.rsp1_result, 64'd0);
    chk("rst_rsp0_err", 64'(bus.rsp0_err), 64'd0);
    chk("rst_alu_op", 64'(bus.alu_operation), 64'd0);
    chk("rst_alu_a", bus.alu_a, 64'd0);
    drive(0, 1'b0, 3'b000, 64'd0, 64'd0);
    @(negedge clk); rst_n = 1'b1;

    // Both requesters valid continuously: grants alternate starting with req0.
    @(negedge clk);
    drive(0, 1'b1, 3'b010, 64'd10, 64'd1);
    drive(1, 1'b1, 3'b010, 64'd20, 64'd2);
    acc = '{0, 0}; pend = '{0, 0}; dropped = 0;
    for (int c = 0; c < 30; c++) begin
      #1;
      for (int p = 0; p < 2; p++) begin
        if (rvld(p)) begin
          chk($sformatf("alt_rsp%0d_latency", p), 64'(cyc - acc[p]), 64'd2);
          chk($sformatf("alt_rsp%0d_result", p), rres(p), (p == 1) ? 64'd22 : 64'd11);
          pend[p] = 0;
        end
      end
      if (g.size() < 4) begin
        for (int p = 0; p < 2; p++) begin
          if (rdy(p)) begin
            g.push_back(p);
            acc[p] = cyc;
            pend[p] = 1;
          end
        end
      end
      if (g.size() >= 4 && !dropped) begin
        @(posedge clk); #1;
        drive(0, 1'b0, 3'b000, 64'd0, 64'd0);
        drive(1, 1'b0, 3'b000, 64'd0, 64'd0);
        dropped = 1;
      end
      if (dropped && pend[0] == 0 && pend[1] == 0) break;
      @(negedge clk);
    end
    chk("alt_grant_count", 64'(g.size()), 64'd4);
    for (int i = 0; i < g.size() && i < 4; i++)
      chk($sformatf("alt_grant%0d", i), 64'(g[i]), 64'(i % 2));

    // Long MUL from req0 while req1 waits; req1 is granted in the response cycle.
    @(negedge clk);
    drive(0, 1'b1, 3'b100, 64'd6, 64'd7);
    drive(1, 1'b1, 3'b010, 64'd3, 64'd4);
    #1;
    chk("mul_ready0", 64'(bus.req0_ready), 64'd1);
    chk("mul_ready1_blocked", 64'(bus.req1_ready), 64'd0);
    t = cyc;
    @(posedge clk); #1;
    drive(0, 1'b0, 3'b000, 64'd0, 64'd0);
    ok = 1;
    for (int k = 1; k <= LL + 1; k++) begin
      @(negedge clk); #1;
      if (k <= LL) begin
        if (bus.req1_ready || bus.rsp0_valid || bus.alu_operation !== 3'b100 ||
            bus.alu_a !== 64'd6 || bus.alu_b !== 64'd7) ok = 0;
      end
    end
    chk("mul_hold", 64'(ok), 64'd1);
    chk("mul_rsp_cycle", 64'(cyc - t), 64'(LL + 1));
    chk("mul_rsp0_valid", 64'(bus.rsp0_valid), 64'd1);
    chk("mul_rsp0_result", bus.rsp0_result, 64'd42);
    chk("mul_ready1_granted", 64'(bus.req1_ready), 64'd1);
    @(posedge clk); #1;
    drive(1, 1'b0, 3'b000, 64'd0, 64'd0);
    @(negedge clk); @(negedge clk); #1;
    chk("mul_rsp1_valid", 64'(bus.rsp1_valid), 64'd1);
    chk("mul_rsp1_result", bus.rsp1_result, 64'd7);

    // Table of single-requester operations.
    for (int i = 0; i < 7; i++) begin
      @(negedge clk);
      run_op(i, vecs[i]);
    end

    // Reset in the middle of a MUL hold.
    @(negedge clk);
    drive(0, 1'b1, 3'b100, 64'd6, 64'd7);
    #1;
    chk("rb_ready0", 64'(bus.req0_ready), 64'd1);
    @(posedge clk); #1;
    drive(0, 1'b0, 3'b000, 64'd0, 64'd0);
    @(posedge clk); @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    chk("rb_alu_op", 64'(bus.alu_operation), 64'd0);
    chk("rb_alu_a", bus.alu_a, 64'd0);
    chk("rb_alu_b", bus.alu_b, 64'd0);
    @(negedge clk); rst_n = 1'b1;
    ok = 1;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk); #1;
      if (bus.rsp0_valid || bus.rsp1_valid) ok = 0;
    end
    chk("rb_no_rsp", 64'(ok), 64'd1);
    @(negedge clk);
    drive(0, 1'b1, 3'b010, 64'd1, 64'd2);
    drive(1, 1'b1, 3'b010, 64'd3, 64'd4);
    #1;
    chk("rb_tie_ready0", 64'(bus.req0_ready), 64'd1);
    chk("rb_tie_ready1", 64'(bus.req1_ready), 64'd0);
    @(posedge clk); #1;
    drive(0, 1'b0, 3'b000, 64'd0, 64'd0);
    drive(1, 1'b0, 3'b000, 64'd0, 64'd0);
    @(negedge clk); @(negedge clk); #1;
    chk("rb_tie_rsp0", 64'(bus.rsp0_valid), 64'd1);
    chk("rb_tie_result", bus.rsp0_result, 64'd3);

    repeat (3) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
